bram_responder: RTL and testbench

Single-port BRAM controller that sits downstream of the u0/u1 arbiter ports and answers their requests. Writes commit in the request cycle. Reads enter a fixed-latency pipeline, and the returned word is routed to either the CPU or the DMA read-return port using a per-request tag. Two instances are used: u0 (CPU/DMA shared) and u1 (DMA-write / FIFO-read).

---
 rtl/bram_responder.sv | 155 +++++++++++++++
 tb/tb_bram_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_responder.sv
// -----------------------------------------------------------------------------
// bram_responder
//
// Single-port BRAM controller that answers requests from an upstream arbiter
// port. Writes commit at the request edge. Reads are captured at the request
// edge and travel down a fixed DELAYS-deep valid/tag/data shift pipeline. The
// returned word is then steered to the CPU or the DMA return port by the tag
// that travelled with it.
//
// Parameters
//   DATA_W  word width
//   ADDR_W  request (word) address width
//   MEM_AW  log2 of physical depth; upper request address bits are ignored
//   DELAYS  read latency in clock edges (1..31)
//
// Ports
//   wb_clk_i         clock, rising edge
//   wb_rst_n         asynchronous active-low reset
//   bram_wr          1 = write, 0 = read (qualified by bram_in_valid)
//   bram_in_valid    request strobe, one request per cycle, no backpressure
//   bram_addr        word address (wraps modulo 2^MEM_AW)
//   bram_data_in     write data
//   bram_reader_sel  read destination tag: 1 = CPU, 0 = DMA
//   cpu_data_o       last word returned to the CPU (held between pulses)
//   cpu_valid_o      one-cycle pulse qualifying cpu_data_o
//   dma_data_o       last word returned to DMA (held between pulses)
//   dma_valid_o      one-cycle pulse qualifying dma_data_o
//   busy_o           high while any read is in flight, output stage included
// -----------------------------------------------------------------------------
module bram_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13,
    parameter int MEM_AW = 11,
    parameter int DELAYS = 10
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              bram_wr,
    input  logic              bram_in_valid,
    input  logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_data_in,
    input  logic              bram_reader_sel,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              cpu_valid_o,
    output logic [DATA_W-1:0] dma_data_o,
    output logic              dma_valid_o,
    output logic              busy_o
);

    localparam int DEPTH = 1 << MEM_AW;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic [MEM_AW-1:0] mem_idx;
    logic              wr_en;
    logic              rd_en;

    assign mem_idx = bram_addr[MEM_AW-1:0];
    assign wr_en   = bram_in_valid &  bram_wr;
    assign rd_en   = bram_in_valid & ~bram_wr;

    // Address bits above MEM_AW are ignored on purpose: the address wraps.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bram_addr;

    // -------------------------------------------------------------------------
    // Storage and read-data pipeline
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] mem         [DEPTH];
    logic [DATA_W-1:0] pipe_data_q [DELAYS];

    // NOTE: memory and the data shift registers carry no reset. A reset branch
    // would stop the array mapping onto block RAM, and the data words are
    // meaningless unless the matching valid bit (which is reset) is set.
    always_ff @(posedge wb_clk_i) begin
        if (wr_en) begin
            mem[mem_idx] <= bram_data_in;
        end
        // Synchronous read port: old contents are sampled at the request edge,
        // so a later write cannot disturb a word already in flight.
        pipe_data_q[0] <= mem[mem_idx];
        for (int k = 1; k < DELAYS; k++) begin
            pipe_data_q[k] <= pipe_data_q[k-1];
        end
    end

    // -------------------------------------------------------------------------
    // Valid/tag pipeline and registered output stage
    // -------------------------------------------------------------------------
    logic [DELAYS-1:0] pipe_valid_d, pipe_valid_q;
    logic [DELAYS-1:0] pipe_tag_d,   pipe_tag_q;
    logic              cpu_valid_d,  cpu_valid_q;
    logic              dma_valid_d,  dma_valid_q;
    logic [DATA_W-1:0] cpu_data_d,   cpu_data_q;
    logic [DATA_W-1:0] dma_data_d,   dma_data_q;

    logic              last_valid;
    logic              last_tag;
    logic [DATA_W-1:0] last_data;

    assign last_valid = pipe_valid_q[DELAYS-1];
    assign last_tag   = pipe_tag_q[DELAYS-1];
    assign last_data  = pipe_data_q[DELAYS-1];

    // NOTE: every signal written here gets a full default assignment first so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        pipe_valid_d    = pipe_valid_q;
        pipe_tag_d      = pipe_tag_q;
        pipe_valid_d[0] = rd_en;
        pipe_tag_d[0]   = bram_reader_sel;
        for (int k = 1; k < DELAYS; k++) begin
            pipe_valid_d[k] = pipe_valid_q[k-1];
            pipe_tag_d[k]   = pipe_tag_q[k-1];
        end

        cpu_valid_d = last_valid &  last_tag;
        dma_valid_d = last_valid & ~last_tag;

        // Each data port only reloads on its own pulse and otherwise holds.
        cpu_data_d = cpu_valid_d ? last_data : cpu_data_q;
        dma_data_d = dma_valid_d ? last_data : dma_data_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; with blocking assignments
    // the shift register would collapse into a single stage.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            pipe_valid_q <= '0;
            pipe_tag_q   <= '0;
            cpu_valid_q  <= 1'b0;
            dma_valid_q  <= 1'b0;
            cpu_data_q   <= '0;
            dma_data_q   <= '0;
        end else begin
            pipe_valid_q <= pipe_valid_d;
            pipe_tag_q   <= pipe_tag_d;
            cpu_valid_q  <= cpu_valid_d;
            dma_valid_q  <= dma_valid_d;
            cpu_data_q   <= cpu_data_d;
            dma_data_q   <= dma_data_d;
        end
    end

    assign cpu_data_o  = cpu_data_q;
    assign cpu_valid_o = cpu_valid_q;
    assign dma_data_o  = dma_data_q;
    assign dma_valid_o = dma_valid_q;

    // Busy covers every stage, including the cycle the return pulse is high.
    assign busy_o = (|pipe_valid_q) | cpu_valid_q | dma_valid_q;

endmodule

// File: tb/tb_bram_responder.sv
// -----------------------------------------------------------------------------
// tb_bram_responder
//
// Drives two bram_responder instances from the same request stream: one at the
// default latency (DELAYS = 10) and one at the minimum latency (DELAYS = 1).
// A behavioural model keeps a word array for memory contents and a list of
// outstanding reads, each stamped with the edge number at which its return
// pulse is due. After every clock edge both instances are compared against the
// model on the falling edge.
// -----------------------------------------------------------------------------
module tb_bram_responder;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 13;
    localparam int MEM_AW = 11;
    localparam int DEPTH  = 2048;
    localparam int LAT0   = 10;
    localparam int LAT1   = 1;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              sel;

    logic [1:0]             cpu_v;
    logic [1:0]             dma_v;
    logic [1:0]             busy;
    logic [1:0][DATA_W-1:0] cpu_d;
    logic [1:0][DATA_W-1:0] dma_d;

    bram_responder #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .DELAYS(LAT0)
    ) u_dut_d10 (
        .wb_clk_i        (clk),
        .wb_rst_n        (rst_n),
        .bram_wr         (wr),
        .bram_in_valid   (in_valid),
        .bram_addr       (addr),
        .bram_data_in    (din),
        .bram_reader_sel (sel),
        .cpu_data_o      (cpu_d[0]),
        .cpu_valid_o     (cpu_v[0]),
        .dma_data_o      (dma_d[0]),
        .dma_valid_o     (dma_v[0]),
        .busy_o          (busy[0])
    );

    bram_responder #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .DELAYS(LAT1)
    ) u_dut_d1 (
        .wb_clk_i        (clk),
        .wb_rst_n        (rst_n),
        .bram_wr         (wr),
        .bram_in_valid   (in_valid),
        .bram_addr       (addr),
        .bram_data_in    (din),
        .bram_reader_sel (sel),
        .cpu_data_o      (cpu_d[1]),
        .cpu_valid_o     (cpu_v[1]),
        .dma_data_o      (dma_d[1]),
        .dma_valid_o     (dma_v[1]),
        .busy_o          (busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    typedef struct {
        int          unit;
        longint      due;
        logic        tag;
        logic [31:0] data;
    } rd_t;

    logic [31:0] ref_mem [DEPTH];
    rd_t         pend [$];
    longint      edge_n;

    logic        exp_cpu_v [2];
    logic        exp_dma_v [2];
    logic        exp_busy  [2];
    logic [31:0] exp_cpu_d [2];
    logic [31:0] exp_dma_d [2];

    int checks = 0;
    int errors = 0;

    task automatic model_reset();
        pend.delete();
        for (int u = 0; u < 2; u++) begin
            exp_cpu_v[u] = 1'b0;
            exp_dma_v[u] = 1'b0;
            exp_busy[u]  = 1'b0;
            exp_cpu_d[u] = '0;
            exp_dma_d[u] = '0;
        end
    endtask

    // Applies one rising edge to the model using the inputs as they stand.
    task automatic model_edge();
        int idx;
        int cnt;
        edge_n++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int u = 0; u < 2; u++) begin
            exp_cpu_v[u] = 1'b0;
            exp_dma_v[u] = 1'b0;
            for (int i = 0; i < pend.size(); i++) begin
                if (pend[i].unit == u && pend[i].due == edge_n) begin
                    if (pend[i].tag) begin
                        exp_cpu_v[u] = 1'b1;
                        exp_cpu_d[u] = pend[i].data;
                    end else begin
                        exp_dma_v[u] = 1'b1;
                        exp_dma_d[u] = pend[i].data;
                    end
                    pend.delete(i);
                    break;
                end
            end
        end
        if (in_valid) begin
            idx = int'(addr) % DEPTH;
            if (wr) begin
                ref_mem[idx] = din;
            end else begin
                pend.push_back('{unit: 0, due: edge_n + LAT0, tag: sel, data: ref_mem[idx]});
                pend.push_back('{unit: 1, due: edge_n + LAT1, tag: sel, data: ref_mem[idx]});
            end
        end
        for (int u = 0; u < 2; u++) begin
            cnt = 0;
            foreach (pend[i]) if (pend[i].unit == u) cnt++;
            exp_busy[u] = (cnt > 0) || exp_cpu_v[u] || exp_dma_v[u];
        end
    endtask

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @edge %0d: observed=%0h expected=%0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d cpu_valid", u), 32'(cpu_v[u]), 32'(exp_cpu_v[u]));
            check($sformatf("u%0d dma_valid", u), 32'(dma_v[u]), 32'(exp_dma_v[u]));
            check($sformatf("u%0d busy", u),      32'(busy[u]),  32'(exp_busy[u]));
            check($sformatf("u%0d cpu_data", u),  cpu_d[u],      exp_cpu_d[u]);
            check($sformatf("u%0d dma_data", u),  dma_d[u],      exp_dma_d[u]);
            check($sformatf("u%0d both_valid", u), 32'(cpu_v[u] & dma_v[u]), 32'd0);
        end
    endtask

    // One clock: model the rising edge, then compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        wr       = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wr_req(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        in_valid = 1'b1;
        wr       = 1'b1;
        addr     = a;
        din      = d;
        sel      = 1'($urandom);
        tick();
        in_valid = 1'b0;
        wr       = 1'b0;
    endtask

    task automatic rd_req(input logic [ADDR_W-1:0] a, input logic s);
        in_valid = 1'b1;
        wr       = 1'b0;
        addr     = a;
        din      = $urandom;
        sel      = s;
        tick();
        in_valid = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        edge_n   = 0;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        wr       = 1'b0;
        addr     = '0;
        din      = '0;
        sel      = 1'b0;

        // Reset held with random read traffic: nothing may come out.
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        for (int n = 0; n < 6; n++) begin
            in_valid = 1'($urandom);
            wr       = 1'b0;
            addr     = 13'($urandom);
            din      = $urandom;
            sel      = 1'($urandom);
            tick();
        end
        rst_n = 1'b1;
        idle(20);

        // Write then read with CPU tag.
        wr_req(13'd5, 32'hDEADBEEF);
        rd_req(13'd5, 1'b1);
        idle(12);

        // Streaming reads, alternating CPU/DMA tags.
        for (int i = 0; i < 8; i++) wr_req(13'(i), 32'(i));
        for (int i = 0; i < 8; i++) rd_req(13'(i), (i % 2) == 0);
        idle(12);

        // Address wrap.
        wr_req(13'h0803, 32'h0000_1234);
        rd_req(13'h0003, 1'b0);
        idle(11);

        // In-flight isolation: the second write must not touch the first read.
        wr_req(13'd9, 32'h0000_000A);
        rd_req(13'd9, 1'b1);
        wr_req(13'd9, 32'h0000_000B);
        rd_req(13'd9, 1'b0);
        idle(12);

        // Reset mid-flight: in-flight reads vanish, memory survives.
        rd_req(13'd0, 1'b1);
        rd_req(13'd1, 1'b0);
        rd_req(13'd2, 1'b1);
        rd_req(13'd3, 1'b0);
        idle(2);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        tick();
        rst_n = 1'b1;
        idle(15);
        rd_req(13'd9, 1'b1);
        rd_req(13'd3, 1'b0);
        idle(12);

        // Random traffic over a preloaded window, with random upper address bits.
        for (int i = 0; i < 32; i++) wr_req(13'(i), $urandom);
        for (int n = 0; n < 300; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            wr       = ($urandom_range(0, 2) == 0);
            addr     = 13'(($urandom_range(0, 3) << 11) | $urandom_range(0, 31));
            din      = $urandom;
            sel      = 1'($urandom);
            tick();
        end
        idle(14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
